// File: rtl/piso_serializer_pkg.sv
// piso_serializer shared types.
// FSM state encoding and counter sizing helper.
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: word register with fill and direction select.
// Emits the current beat slice from the end chosen at load time.
module piso_shift_core #(
   parameter int   INPUT_WIDTH = 8,
   parameter int   LANES       = 1,
   parameter logic VALUE_PULL  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic                   shift_en,
   input  logic                   dir_in,
   input  logic [INPUT_WIDTH-1:0] word_in,
   output logic [LANES-1:0]       beat
);

   logic [INPUT_WIDTH-1:0] word_q, word_d;
   logic [INPUT_WIDTH-1:0] shr, shl;
   logic                   dir_q, dir_d;

   // shifted images; one-beat words drain straight to fill
   if (LANES == INPUT_WIDTH) begin : g_full
      assign shr = {INPUT_WIDTH{VALUE_PULL}};
      assign shl = {INPUT_WIDTH{VALUE_PULL}};
   end else begin : g_part
      assign shr = {{LANES{VALUE_PULL}},
                    word_q[INPUT_WIDTH-1:LANES]};
      assign shl = {word_q[INPUT_WIDTH-LANES-1:0],
                    {LANES{VALUE_PULL}}};
   end

   // next word: a load beats a shift in the same cycle
   always_comb begin
      word_d = word_q;
      dir_d  = dir_q;
      if (load) begin
         word_d = word_in;
         dir_d  = dir_in;
      end else if (shift_en) begin
         word_d = dir_q ? shl : shr;
      end
   end

   // register state; reset parks at the fill level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= {INPUT_WIDTH{VALUE_PULL}};
         dir_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         dir_q  <= dir_d;
      end
   end

   assign beat = dir_q ? word_q[INPUT_WIDTH-1:INPUT_WIDTH-LANES]
                       : word_q[LANES-1:0];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out converter.
// Zero-bubble reload on the last beat; per-word shift direction.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   INPUT_WIDTH = 8,
   parameter int   LANES       = 1,
   parameter logic VALUE_PULL  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] in_data,
   input  logic                   dir,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES-1:0]       out_data,
   output logic                   out_last,
   output logic                   busy
);

   localparam int BEATS = INPUT_WIDTH / LANES;
   localparam int CW    = cnt_width(BEATS);
   localparam logic [CW-1:0] BEATS_M1 = CW'(BEATS - 1);

   if (INPUT_WIDTH < 1 || LANES < 1 ||
       (INPUT_WIDTH % LANES) != 0) begin : g_bad_cfg
      $error("piso_serializer: LANES must divide INPUT_WIDTH");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load, accept;

   assign out_valid = (state_q == SHIFT);
   assign out_last  = out_valid & (cnt_q == '0);
   assign busy      = out_valid;
   assign accept    = out_valid & out_ready;
   assign in_ready  = (state_q == IDLE) | (accept & out_last);
   assign load      = in_valid & in_ready;

   // next state and beat count; a same-cycle load keeps SHIFT
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (load) begin
         state_d = SHIFT;
         cnt_d   = BEATS_M1;
      end else if (accept) begin
         cnt_d = out_last ? '0 : cnt_q - 1'b1;
         if (out_last) state_d = IDLE;
      end
   end

   // FSM and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   piso_shift_core #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .LANES       (LANES),
      .VALUE_PULL  (VALUE_PULL)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .shift_en (accept),
      .dir_in   (dir),
      .word_in  (in_data),
      .beat     (out_data)
   );

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer. It supersedes the fixed-direction piso_right / piso_left pair.
- Adds a valid/ready handshake on both sides.
- Adds multi-bit lanes per shift.
- Selects shift direction per word.
- Adds word framing (out_last) and a busy flag.
It sits between a word-oriented producer and a narrow serial link or pin driver.

Parameters:
INPUT_WIDTH, 8, parallel word width in bits; must be >= 1.
LANES, 1, bits emitted per beat; must divide INPUT_WIDTH exactly (elaboration-time check, $error otherwise).
VALUE_PULL, 1'b1, fill value shifted into vacated bits; also the idle level of out_data.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a word on in_data
in_ready  out  1  serializer accepts a word this cycle
in_data  in  INPUT_WIDTH  parallel word
dir  in  1  sampled with the word: 0 = right shift (LSB slice first), 1 = left shift (MSB slice first)
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  consumer takes the beat this cycle
out_data  out  LANES  current beat
out_last  out  1  current beat is the final beat of its word
busy  out  1  a word is loaded and not fully drained

Behaviour:
- BEATS = INPUT_WIDTH/LANES.
- Beat counter width = max(1, $clog2(BEATS)).
- Reset (async assert, sync release):
  - shift register = all VALUE_PULL; out_valid = 0; out_last = 0; busy = 0; counter = 0; state = IDLE.
  - out_data = {LANES{VALUE_PULL}}.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). The second term allows back-to-back words with zero bubbles.
- Load (in_valid & in_ready at an edge):
  - shift register <= in_data; latched dir <= dir; counter <= BEATS-1; state -> SHIFT.
  - The first beat appears on out_data the cycle after the load edge (1-cycle latency).
- out_data is a combinational slice of the shift register:
  - latched dir = 0: bits [LANES-1:0].
  - latched dir = 1: bits [INPUT_WIDTH-1:INPUT_WIDTH-LANES].
- out_valid = (state==SHIFT).
- out_last = (state==SHIFT) & (counter==0).
- busy = out_valid.
- Beat accepted (out_valid & out_ready):
  - Register shifts by LANES toward the emitted end; vacated bits are filled with VALUE_PULL.
  - counter decrements.
  - If out_last: state -> IDLE, unless a new load occurs in the same cycle. In that case the load wins: the register is reloaded and state stays SHIFT.
- Backpressure: while out_ready = 0, the register, counter and out_data hold stable. out_valid stays high (no retraction).
- in_data and dir are ignored when in_ready = 0.
- dir changes mid-word have no effect.
- LANES == INPUT_WIDTH: BEATS = 1, and every beat is last.
- After the final beat, with no new load, out_data returns to all VALUE_PULL.
- Reset mid-word: the word is discarded immediately (async). No partial beat follows release.

Decomposition:
- No shared package is required. BEATS and the counter width are local parameters.
- One natural sub-module: piso_shift_core. It holds the shift register, fill logic and direction select (load, shift_en, dir in; word out).
- The top level holds the FSM, counter and handshake.

Test Plan:
- INPUT_WIDTH=8, LANES=1, VALUE_PULL=1; load 8'b11011000 with dir=0 and out_ready=1 held.
  - Required: out_data 0,0,0,1,1,0,1,1.
  - Required: out_last only on beat 8; then out_data = 1 idle.
- Same word with dir=1.
  - Required: out_data 1,1,0,1,1,0,0,0.
- LANES=2, 8'hD8.
  - dir=1 -> beats 2'b11, 2'b01, 2'b10, 2'b00.
  - dir=0 -> beats 2'b00, 2'b10, 2'b01, 2'b11.
  - Required: 4 beats per word.
- Backpressure: drop out_ready for 3 cycles after beat 3.
  - Required: out_data and out_valid held stable; sequence unchanged; busy high throughout.
- Back-to-back: in_valid held high with 8'hD8 then 8'h28, dir=0, LANES=1.
  - Required: 16 contiguous beats, no bubble.
  - Required: in_ready pulses exactly on the two last beats.
  - Required: second word's beats = 0,0,0,1,0,1,0,0.
- Assert rst_n low mid-word, asynchronously between edges.
  - Required: out_valid, busy and out_last drop immediately; out_data = all VALUE_PULL.
  - Required: after release, the next load serializes cleanly from beat 1.
